rans_out_stack: RTL and testbench
=================================

# rans_out_stack

Byte-reversal LIFO that sits directly downstream of the rANS encoder. It captures every renormalisation byte the encoder emits, then on flush appends the encoder's final state. It drains everything in reverse order over a valid/ready stream, so the decoder receives the final state first and the renormalisation bytes in the order it consumes them.

## Interface
- SYMBOL_WIDTH, 8, byte width of encoder output and output stream
- STATE_WIDTH, 18, encoder state width; STATE_BYTES = ceil(STATE_WIDTH / SYMBOL_WIDTH)
- DEPTH_LOG2, 10, stack capacity = 2**DEPTH_LOG2 entries; legal range 2..16

- clk_i  input  1  clock; all logic on rising edge
- rst_i  input  1  asynchronous, active-high reset
- valid_i  input  1  encoder byte strobe
- enc_i  input  SYMBOL_WIDTH  encoder byte
- flush_i  input  1  one-cycle end-of-block pulse, sampled with the final state
- state_i  input  STATE_WIDTH  encoder state, captured when flush_i=1
- out_valid_o  output  1  output byte valid
- out_data_o  output  SYMBOL_WIDTH  output byte
- out_last_o  output  1  final byte of block; qualified by out_valid_o
- out_ready_i  input  1  downstream accept
- busy_o  output  1  high in FLUSH and DRAIN; encoder must not start a new block
- overflow_o  output  1  sticky: a byte was dropped because the stack was full
- count_o  output  DEPTH_LOG2+1  current occupancy

## Operation
- FSM states: FILL, FLUSH, DRAIN. Reset enters FILL with count 0.
- Reset values: out_valid_o=0, out_data_o=0, out_last_o=0, busy_o=0, overflow_o=0, count_o=0.
- FILL:
  - valid_i=1 writes enc_i at the stack pointer and increments count.
  - flush_i=1 latches state_i and moves to FLUSH.
  - valid_i and flush_i in the same cycle: the byte is pushed first, then the state is latched.
- FLUSH: pushes STATE_BYTES state bytes, one per cycle, least-significant byte first. They therefore pop most-significant first. Moves to DRAIN when done.
- Push while count = 2**DEPTH_LOG2: the byte is discarded, count holds, and overflow_o is set. This applies to encoder bytes and state bytes alike.
- DRAIN:
  - Pops top of stack to out_data_o.
  - A byte transfers on out_valid_o & out_ready_i.
  - out_last_o=1 on the transfer that empties the stack.
  - Returns to FILL the cycle after the last transfer; busy_o drops there.
- valid_i or flush_i during FLUSH/DRAIN: ignored and dropped; overflow_o is set.
- Flush with zero encoder bytes is legal: only the state bytes (plus header if enabled) are emitted.
- Backpressure: out_data_o and out_last_o hold stable while out_valid_o=1 and out_ready_i=0.
- Storage is a synchronous-read RAM of depth 2**DEPTH_LOG2 with a single pointer. A one-entry output register plus a prefetch/skid register keeps throughput at one byte per cycle.
- overflow_o clears only on rst_i.
- Reset mid-operation discards all contents and returns to FILL.

## Timing
- Push: count_o reflects a push on the cycle after valid_i.
- FLUSH lasts exactly STATE_BYTES cycles (STATE_BYTES+2 with header).
- First out_valid_o is asserted 2 cycles after DRAIN entry.
- With out_ready_i held high, one byte transfers every cycle, with no bubbles, until out_last_o.
- out_ready_i falling stalls the stream with zero bytes lost or duplicated. It may toggle every cycle.
- count_o decrements on the cycle after each transfer.

## Configuration
- RANS_OUT_STACK_LEN_HEADER_EN defined:
  - After the state bytes, FLUSH pushes a 2*SYMBOL_WIDTH-bit length header.
  - The header value is the occupancy before header push: encoder bytes + STATE_BYTES.
  - It is pushed low byte first, so it pops first, most-significant byte first.
  - The header obeys the same overflow rule as other pushes.
- Macro undefined: no header; the stream starts with the state bytes.

## Test plan
- Push 0x11,0x22,0x33; flush with state_i=0x2ABCD; out_ready_i=1.
  - Required output: 0x02,0xAB,0xCD,0x33,0x22,0x11 on consecutive cycles, out_last_o only on 0x11.
  - count_o sequence during the drain: 6..0.
- Same stimulus, with out_ready_i toggled 1,0,0,1 repeating -> identical byte sequence, data stable during stalls, no duplicates.
- DEPTH_LOG2=2: push 0xA0..0xA4 (5 bytes), then flush with state 0x00001.
  - Required: overflow_o=1 after the 5th push; count_o=4.
  - Output: 0xA3,0xA2,0xA1,0xA0 with last on 0xA0; all state bytes dropped.
- Flush alone with state_i=0x3FFFF -> 0x03,0xFF,0xFF, last on the final 0xFF; busy_o low the cycle after.
- valid_i=1 with enc_i=0x55 in the same cycle as flush_i with state 0x10400 -> output 0x01,0x04,0x00,0x55.
- Assert rst_i mid-DRAIN after 2 transfers -> all outputs 0 immediately, FILL state. A new block then drains correctly.
- With RANS_OUT_STACK_LEN_HEADER_EN: the first scenario outputs 0x00,0x06 before 0x02.

Source files
------------

// File: rtl/rans_out_stack.sv
// rans_out_stack: byte-reversal LIFO behind the rANS encoder; drains the final state first, then the renorm bytes.
// Define RANS_OUT_STACK_LEN_HEADER_EN to push a 2-byte length header after the state bytes.
module rans_out_stack #(
  parameter int SYMBOL_WIDTH = 8,
  parameter int STATE_WIDTH  = 18,
  parameter int DEPTH_LOG2   = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  input  logic [SYMBOL_WIDTH-1:0] enc_i,
  input  logic                    flush_i,
  input  logic [STATE_WIDTH-1:0]  state_i,
  output logic                    out_valid_o,
  output logic [SYMBOL_WIDTH-1:0] out_data_o,
  output logic                    out_last_o,
  input  logic                    out_ready_i,
  output logic                    busy_o,
  output logic                    overflow_o,
  output logic [DEPTH_LOG2:0]     count_o
);
  localparam int SB = (STATE_WIDTH + SYMBOL_WIDTH - 1) / SYMBOL_WIDTH;
  localparam int PW = SB * SYMBOL_WIDTH;
  localparam int HW = 2 * SYMBOL_WIDTH;
`ifdef RANS_OUT_STACK_LEN_HEADER_EN
  localparam int FN = SB + 2;
`else
  localparam int FN = SB;
`endif
  localparam int IW = $clog2(FN) + 1;
  localparam int CW = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {FILL, FLUSH, DRAIN} st_t;

  st_t                     st_q, st_d;
  logic [PW-1:0]           state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d, ptr_q, ptr_d;
  logic                    ovf_q, ovf_d;
  logic                    ov_q, ov_d, sv_q, sv_d, rv_q;
  logic [SYMBOL_WIDTH-1:0] od_q, od_d, sd_q, sd_d, rdata_q;
  logic [SYMBOL_WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [SYMBOL_WIDTH-1:0] push_data;
  logic [DEPTH_LOG2-1:0]   raddr;
  logic [1:0]              occ;
  logic                    push, full, pop, rd_en;
  logic [FN*SYMBOL_WIDTH-1:0] fvec;

`ifdef RANS_OUT_STACK_LEN_HEADER_EN
  logic [HW-1:0] hdr_q, hdr_d;
  assign fvec = {hdr_q, state_q};
`else
  assign fvec = state_q;
`endif

  assign full  = cnt_q[DEPTH_LOG2];
  assign pop   = ov_q & out_ready_i;
  assign raddr = ptr_q[DEPTH_LOG2-1:0] - 1'b1;
  // Output reg, skid reg and the in-flight RAM read together never hold more than two bytes.
  assign occ   = {1'b0, ov_q} + {1'b0, sv_q} + {1'b0, rv_q};
  assign rd_en = st_q == DRAIN && ptr_q != '0 && (occ < 2'd2 || (occ == 2'd2 && pop));

  always_comb begin
    st_d      = st_q;
    state_d   = state_q;
    idx_d     = idx_q;
    ovf_d     = ovf_q;
    push      = 1'b0;
    push_data = enc_i;
    case (st_q)
      FILL: begin
        push = valid_i;
        if (flush_i) begin
          st_d    = FLUSH;
          state_d = PW'(state_i);
          idx_d   = '0;
        end
      end
      FLUSH: begin
        push      = 1'b1;
        push_data = fvec[idx_q*SYMBOL_WIDTH +: SYMBOL_WIDTH];
        ovf_d     = ovf_q | valid_i | flush_i;
        st_d      = idx_q == IW'(FN - 1) ? DRAIN : FLUSH;
        idx_d     = idx_q + 1'b1;
      end
      DRAIN: begin
        ovf_d = ovf_q | valid_i | flush_i;
        if (cnt_q == '0 || (pop && cnt_q == CW'(1))) st_d = FILL;
      end
      default: st_d = FILL;
    endcase
    if (push && full) ovf_d = 1'b1;
    cnt_d = push && !full ? cnt_q + 1'b1 : pop ? cnt_q - 1'b1 : cnt_q;
    ptr_d = push && !full ? ptr_q + 1'b1 : rd_en ? ptr_q - 1'b1 : ptr_q;
`ifdef RANS_OUT_STACK_LEN_HEADER_EN
    hdr_d = (st_q == FLUSH && idx_q == IW'(SB - 1)) ? HW'(cnt_d) : hdr_q;
`endif
    ov_d = pop ? sv_q : ov_q;
    od_d = pop ? sd_q : od_q;
    sv_d = sv_q & ~pop;
    sd_d = sd_q;
    if (rv_q) begin
      if (ov_d) begin
        sv_d = 1'b1;
        sd_d = rdata_q;
      end else begin
        ov_d = 1'b1;
        od_d = rdata_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q    <= FILL;
      state_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      ov_q    <= 1'b0;
      sv_q    <= 1'b0;
      rv_q    <= 1'b0;
      od_q    <= '0;
      sd_q    <= '0;
`ifdef RANS_OUT_STACK_LEN_HEADER_EN
      hdr_q   <= '0;
`endif
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      ov_q    <= ov_d;
      sv_q    <= sv_d;
      rv_q    <= rd_en;
      od_q    <= od_d;
      sd_q    <= sd_d;
`ifdef RANS_OUT_STACK_LEN_HEADER_EN
      hdr_q   <= hdr_d;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !full) mem[ptr_q[DEPTH_LOG2-1:0]] <= push_data;
    if (rd_en) rdata_q <= mem[raddr];
  end

  assign out_valid_o = ov_q;
  assign out_data_o  = od_q;
  assign out_last_o  = ov_q && cnt_q == CW'(1);
  assign busy_o      = st_q != FILL;
  assign overflow_o  = ovf_q;
  assign count_o     = cnt_q;
endmodule

// File: tb/tb_rans_out_stack.sv
// tb_rans_out_stack: directed vectors for the rANS output stack; a depth-4 instance covers overflow.
module tb_rans_out_stack;
`ifdef RANS_OUT_STACK_LEN_HEADER_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif
  localparam int FN = 3 + HDR;

  typedef struct {
    int               nb;
    logic [0:3][7:0]  b;
    logic [17:0]      st;
    bit               merge;
    bit               tog;
    int               ne;
    logic [0:7][7:0]  e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0, valid = 1'b0, flush = 1'b0, rdy = 1'b1;
  logic [7:0]  enc = '0;
  logic [17:0] st = '0;
  logic a_v, a_l, a_b, a_f, b_v, b_l, b_b, b_f;
  logic [7:0]  a_d, b_d;
  logic [10:0] a_c;
  logic [2:0]  b_c;
  logic o_v, o_l, o_b, o_f;
  logic [7:0]  o_d;
  logic [10:0] o_c;
  int n_cmp = 0, n_bad = 0;
  vec_t tbl[4];

  always #5 clk = ~clk;

  assign o_v = sel ? b_v : a_v;
  assign o_l = sel ? b_l : a_l;
  assign o_b = sel ? b_b : a_b;
  assign o_f = sel ? b_f : a_f;
  assign o_d = sel ? b_d : a_d;
  assign o_c = sel ? {8'b0, b_c} : a_c;

  rans_out_stack dut_a (
    .clk_i(clk), .rst_i(rst), .valid_i(valid & ~sel), .enc_i(enc),
    .flush_i(flush & ~sel), .state_i(st), .out_valid_o(a_v), .out_data_o(a_d),
    .out_last_o(a_l), .out_ready_i(rdy), .busy_o(a_b), .overflow_o(a_f), .count_o(a_c)
  );

  rans_out_stack #(.DEPTH_LOG2(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .valid_i(valid & sel), .enc_i(enc),
    .flush_i(flush & sel), .state_i(st), .out_valid_o(b_v), .out_data_o(b_d),
    .out_last_o(b_l), .out_ready_i(rdy), .busy_o(b_b), .overflow_o(b_f), .count_o(b_c)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [0:9][7:0] build_x(input vec_t v);
    logic [0:9][7:0] x = '0;
    int hdr = v.nb + 3;
    for (int i = 0; i < HDR; i++) x[i] = 8'(hdr >> (8 * (HDR - 1 - i)));
    for (int i = 0; i < v.ne; i++) x[i + HDR] = v.e[i];
    return x;
  endfunction

  // Called at the negedge where flush was driven; checks every valid cycle against the expected byte.
  task automatic drain(input string nm, input int ne, input logic [0:9][7:0] x, input bit tog, input int lat);
    int w = 0, j = 0, k = 0;
    @(negedge clk);
    flush = 1'b0;
    valid = 1'b0;
    rdy   = 1'b1;
    chk({nm, " busy"}, o_b, 1);
    while (!o_v && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (lat >= 0) chk({nm, " latency"}, w, lat);
    while (j < ne && k < 200) begin
      rdy = tog ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
      if (!tog) chk({nm, " no bubble"}, o_v, 1);
      if (o_v) begin
        chk($sformatf("%s data[%0d]", nm, j), o_d, x[j]);
        chk($sformatf("%s last[%0d]", nm, j), o_l, j == ne - 1);
        if (rdy) begin
          chk($sformatf("%s count[%0d]", nm, j), o_c, ne - j);
          j++;
        end
      end
      @(negedge clk);
      k++;
    end
    chk({nm, " all bytes"}, j, ne);
    chk({nm, " busy after"}, o_b, 0);
    chk({nm, " valid after"}, o_v, 0);
    chk({nm, " count after"}, o_c, 0);
    rdy = 1'b1;
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int np = v.nb - (v.merge ? 1 : 0);
    sel = 1'b0;
    for (int i = 0; i < np; i++) begin
      valid = 1'b1;
      enc   = v.b[i];
      @(negedge clk);
    end
    valid = 1'b0;
    chk({nm, " fill count"}, o_c, np);
    valid = v.merge;
    enc   = v.b[v.merge ? v.nb - 1 : 0];
    flush = 1'b1;
    st    = v.st;
    drain(nm, v.ne + HDR, build_x(v), v.tog, FN + 2);
    chk({nm, " no overflow"}, o_f, 0);
  endtask

  initial begin
    logic [0:9][7:0] x0;
    int w;
    tbl[0] = '{nb: 3, b: {8'h11, 8'h22, 8'h33, 8'h00}, st: 18'h2ABCD, merge: 0, tog: 0,
               ne: 6, e: {8'h02, 8'hAB, 8'hCD, 8'h33, 8'h22, 8'h11, 16'h0}};
    tbl[1] = tbl[0];
    tbl[1].tog = 1;
    tbl[2] = '{nb: 0, b: '0, st: 18'h3FFFF, merge: 0, tog: 0,
               ne: 3, e: {8'h03, 8'hFF, 8'hFF, 40'h0}};
    tbl[3] = '{nb: 1, b: {8'h55, 24'h0}, st: 18'h10400, merge: 1, tog: 0,
               ne: 4, e: {8'h01, 8'h04, 8'h00, 8'h55, 32'h0}};

    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("reset valid", o_v, 0);
      chk("reset data", o_d, 0);
      chk("reset last", o_l, 0);
      chk("reset busy", o_b, 0);
      chk("reset overflow", o_f, 0);
      chk("reset count", o_c, 0);
    end
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Mid-drain: an ignored push sets overflow, then async reset clears everything.
    x0 = build_x(tbl[0]);
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1;
      enc   = tbl[0].b[i];
      @(negedge clk);
    end
    valid = 1'b0;
    flush = 1'b1;
    st    = tbl[0].st;
    @(negedge clk);
    flush = 1'b0;
    w = 0;
    while (!a_v && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("mid first", a_d, x0[0]);
    valid = 1'b1;
    enc   = 8'h99;
    @(negedge clk);
    valid = 1'b0;
    chk("mid ignored push overflow", a_f, 1);
    chk("mid count", a_c, 5 + HDR);
    chk("mid second", a_d, x0[1]);
    @(negedge clk);
    chk("mid third", a_d, x0[2]);
    #1 rst = 1'b1;
    #1;
    chk("rst valid", a_v, 0);
    chk("rst data", a_d, 0);
    chk("rst last", a_l, 0);
    chk("rst busy", a_b, 0);
    chk("rst overflow", a_f, 0);
    chk("rst count", a_c, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec("after reset", tbl[0]);

    // Depth-4 instance: fifth byte and every state byte are dropped.
    sel = 1'b1;
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1;
      enc   = 8'hA0 + 8'(i);
      @(negedge clk);
      if (i == 3) begin
        chk("ovf before full push", o_f, 0);
        chk("ovf count 4", o_c, 4);
      end
      if (i == 4) begin
        chk("ovf set", o_f, 1);
        chk("ovf count held", o_c, 4);
      end
    end
    valid = 1'b0;
    flush = 1'b1;
    st    = 18'h00001;
    drain("ovf", 4, {8'hA3, 8'hA2, 8'hA1, 8'hA0, 48'h0}, 1'b0, -1);
    chk("ovf sticky", o_f, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
